// File: rtl/prio_req_arbiter.sv
// prio_req_arbiter: captures rising edges on eight request lines into a
// pending register. It offers the highest-priority pending, unmasked line
// as a held 3-bit index on a valid/ready port. An offer is never retracted
// once made, and the line's pending bit is cleared when the offer is accepted.
module prio_req_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       out_ready,
  input  logic       clr_ovr,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic [7:0] pending,
  output logic [7:0] overrun,
  output logic [7:0] drop_cnt
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state;
  logic [7:0] req_d;
  logic [7:0] rise;
  logic [7:0] clr_bit;
  logic [7:0] pending_next;
  logic [7:0] ovr_ev;
  logic [7:0] overrun_next;
  logic [3:0] ovr_pop;
  logic [8:0] drop_sum;
  logic [7:0] drop_next;
  logic [7:0] eligible;

  // Highest set index wins; an all-zero vector maps to 0 (never used that way)
  function automatic logic [2:0] prio_index(input logic [7:0] v);
    prio_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) prio_index = i[2:0];
    end
  endfunction

  // Next-state terms for pending, overrun flags and the saturating drop counter
  always_comb begin
    rise     = req & ~req_d;
    clr_bit  = (out_valid && out_ready) ? (8'd1 << out_code) : 8'd0;
    // A new edge on the line being accepted re-arms it rather than being lost
    pending_next = (pending & ~clr_bit) | rise;
    ovr_ev   = rise & pending & ~clr_bit;
    overrun_next = clr_ovr ? ovr_ev : (overrun | ovr_ev);
    ovr_pop  = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ovr_pop = ovr_pop + {3'd0, ovr_ev[i]};
    end
    drop_sum  = (clr_ovr ? 9'd0 : {1'b0, drop_cnt}) + {5'd0, ovr_pop};
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    eligible  = pending & mask;
  end

  // Edge history, pending capture and overrun bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d    <= 8'd0;
      pending  <= 8'd0;
      overrun  <= 8'd0;
      drop_cnt <= 8'd0;
    end else begin
      req_d    <= req;
      pending  <= pending_next;
      overrun  <= overrun_next;
      drop_cnt <= drop_next;
    end
  end

  // Offer FSM: pick a line from the registered pending state, then hold it until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_code  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible != 8'd0) begin
            state     <= OFFER;
            out_valid <= 1'b1;
            out_code  <= prio_index(eligible);
          end
        end
        OFFER: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_req_arbiter.sv
// tb_prio_req_arbiter: scoreboard bench for prio_req_arbiter. Expected grant
// codes are queued as requests are raised and popped when a handshake is seen.
module tb_prio_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       out_ready;
  logic       clr_ovr;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] pending;
  logic [7:0] overrun;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [2:0] sb[$];
  int ovr_model;

  prio_req_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .out_valid (out_valid),
    .out_code  (out_code),
    .pending   (pending),
    .overrun   (overrun),
    .drop_cnt  (drop_cnt)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m,
                               input logic rdy, input logic clr);
    req       = r;
    mask      = m;
    out_ready = rdy;
    clr_ovr   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: each accepted offer must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) checkOutput("sb_unexpected_grant", sb.size(), 1);
      else checkOutput("grant_code", out_code, sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_code", out_code, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Single request
    $display("[TB] single request");
    applyStimulus(8'h10, 8'hFF, 1'b1, 1'b0);
    sb.push_back(3'd4);
    tick();
    checkOutput("single_pending", pending, 8'h10);
    checkOutput("single_valid_lat1", out_valid, 0);
    tick();
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_code", out_code, 4);
    tick();
    checkOutput("single_cleared", pending, 8'h00);
    checkOutput("single_bubble", out_valid, 0);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
    tick();

    // Priority order
    $display("[TB] priority order");
    applyStimulus(8'h81, 8'hFF, 1'b1, 1'b0);
    sb.push_back(3'd7);
    sb.push_back(3'd0);
    tick();
    checkOutput("prio_pending0", pending, 8'h81);
    tick();
    checkOutput("prio_code7", out_code, 7);
    tick();
    checkOutput("prio_pending1", pending, 8'h01);
    checkOutput("prio_bubble", out_valid, 0);
    tick();
    checkOutput("prio_valid0", out_valid, 1);
    checkOutput("prio_code0", out_code, 0);
    tick();
    checkOutput("prio_pending2", pending, 8'h00);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
    tick();

    // Hold under backpressure
    $display("[TB] hold under backpressure");
    applyStimulus(8'h04, 8'hFF, 1'b0, 1'b0);
    sb.push_back(3'd2);
    sb.push_back(3'd6);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) applyStimulus(8'h44, 8'hFF, 1'b0, 1'b0);
      tick();
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_code", out_code, 2);
    end
    checkOutput("hold_pending", pending, 8'h44);
    applyStimulus(8'h44, 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("hold_after_accept", pending, 8'h40);
    tick();
    checkOutput("hold_next_code", out_code, 6);
    tick();
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
    tick();

    // Mask
    $display("[TB] mask");
    applyStimulus(8'h0C, 8'h04, 1'b1, 1'b0);
    sb.push_back(3'd2);
    tick();
    tick();
    checkOutput("mask_code2", out_code, 2);
    tick();
    tick();
    checkOutput("mask_blocked_valid", out_valid, 0);
    checkOutput("mask_blocked_pending", pending, 8'h08);
    applyStimulus(8'h0C, 8'hFF, 1'b1, 1'b0);
    sb.push_back(3'd3);
    tick();
    checkOutput("mask_code3", out_code, 3);
    tick();
    checkOutput("mask_drained", pending, 8'h00);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
    tick();

    // Overrun and saturation
    $display("[TB] overrun and saturation");
    applyStimulus(8'h20, 8'hFF, 1'b0, 1'b0);
    sb.push_back(3'd5);
    tick();
    tick();
    ovr_model = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h20, 8'hFF, 1'b0, 1'b0);
      tick();
      ovr_model++;
      if (i == 9) checkOutput("ovr_drop10", drop_cnt, ovr_model);
    end
    checkOutput("ovr_flags", overrun, 8'h20);
    checkOutput("ovr_drop_sat", drop_cnt, (ovr_model > 255) ? 255 : ovr_model);
    checkOutput("ovr_still_offer", out_code, 5);
    applyStimulus(8'h20, 8'hFF, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h20, 8'hFF, 1'b0, 1'b0);
    checkOutput("clr_overrun", overrun, 8'h00);
    checkOutput("clr_drop", drop_cnt, 0);
    // Set-vs-clear: new edge on bit 5 in the accept cycle
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h20, 8'hFF, 1'b1, 1'b0);
    sb.push_back(3'd5);
    tick();
    checkOutput("setclr_pending", pending, 8'h20);
    checkOutput("setclr_overrun", overrun, 8'h00);
    checkOutput("setclr_drop", drop_cnt, 0);
    tick();
    checkOutput("setclr_regrant", out_code, 5);
    tick();
    checkOutput("setclr_drained", pending, 8'h00);
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
    tick();

    // Async reset mid-offer
    $display("[TB] async reset mid-offer");
    applyStimulus(8'h02, 8'hFF, 1'b0, 1'b0);
    sb.push_back(3'd1);
    tick();
    tick();
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h02, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("arst_pre_valid", out_valid, 1);
    checkOutput("arst_pre_drop", drop_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", out_valid, 0);
    checkOutput("arst_pending", pending, 0);
    checkOutput("arst_drop", drop_cnt, 0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    sb.push_back(3'd1);
    tick();
    checkOutput("arst_rel_pending", pending, 8'h02);
    checkOutput("arst_rel_valid1", out_valid, 0);
    tick();
    checkOutput("arst_rel_valid2", out_valid, 1);
    checkOutput("arst_rel_code", out_code, 1);
    applyStimulus(8'h02, 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("arst_rel_drained", pending, 8'h00);
    tick();

    checkOutput("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
